// File: rtl/regfile_arbiter_if.sv
// One requester's port into the regfile arbiter: a read/optional-write request
// handshake plus a registered response handshake carrying both read results.
interface regfile_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;

    modport master (
        output valid, we, rs1, rs2, rd, wdata, rready,
        input  ready, rvalid, rdata1, rdata2
    );

    modport slave (
        input  valid, we, rs1, rs2, rd, wdata, rready,
        output ready, rvalid, rdata1, rdata2
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the regfile's two read ports and one write port
// between requesters A and B; one grant per transaction, registered responses.
module regfile_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    regfile_arbiter_if.slave a,
    regfile_arbiter_if.slave b,
    output logic [AW-1:0] rf_readreg1,
    output logic [AW-1:0] rf_readreg2,
    output logic [AW-1:0] rf_writereg,
    output logic [DW-1:0] rf_data,
    output logic          rf_writeEn,
    input  logic [DW-1:0] rf_rs1,
    input  logic [DW-1:0] rf_rs2,
    output logic          last_grant,
    output logic [7:0]    txn_cnt
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q;
    logic          last_grant_q;
    logic [7:0]    txn_cnt_q;
    logic          a_rvalid_q, b_rvalid_q;
    logic [DW-1:0] a_rdata1_q, a_rdata2_q, b_rdata1_q, b_rdata2_q;

    logic grant_a, grant_b, release_resp;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d      = state_q;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        release_resp = 1'b0;
        rf_readreg1  = '0;
        rf_readreg2  = '0;
        rf_writereg  = '0;
        rf_data      = '0;
        rf_writeEn   = 1'b0;

        case (state_q)
            IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (a.valid && (!b.valid || last_grant_q)) begin
                    grant_a = 1'b1;
                end else if (b.valid) begin
                    grant_b = 1'b1;
                end

                if (grant_a) begin
                    rf_readreg1 = a.rs1;
                    rf_readreg2 = a.rs2;
                    rf_writereg = a.rd;
                    rf_data     = a.wdata;
                    rf_writeEn  = a.we;
                end else if (grant_b) begin
                    rf_readreg1 = b.rs1;
                    rf_readreg2 = b.rs2;
                    rf_writereg = b.rd;
                    rf_data     = b.wdata;
                    rf_writeEn  = b.we;
                end

                if (grant_a || grant_b) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                // Only the owner's rready ends the response phase.
                release_resp = owner_q ? b.rready : a.rready;
                if (release_resp) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: all flops use non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read data is sampled at the grant edge, the same edge the regfile commits
    // the write, so a read of rd returns the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            txn_cnt_q    <= 8'd0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata1_q   <= '0;
            a_rdata2_q   <= '0;
            b_rdata1_q   <= '0;
            b_rdata2_q   <= '0;
        end else begin
            if (grant_a) begin
                a_rdata1_q <= rf_rs1;
                a_rdata2_q <= rf_rs2;
                a_rvalid_q <= 1'b1;
            end
            if (grant_b) begin
                b_rdata1_q <= rf_rs1;
                b_rdata2_q <= rf_rs2;
                b_rvalid_q <= 1'b1;
            end
            if (grant_a || grant_b) begin
                owner_q      <= grant_b;
                last_grant_q <= grant_b;
                txn_cnt_q    <= txn_cnt_q + 8'd1;
            end
            if (release_resp) begin
                if (owner_q) begin
                    b_rvalid_q <= 1'b0;
                end else begin
                    a_rvalid_q <= 1'b0;
                end
            end
        end
    end

    assign a.ready    = grant_a;
    assign b.ready    = grant_b;
    assign a.rvalid   = a_rvalid_q;
    assign b.rvalid   = b_rvalid_q;
    assign a.rdata1   = a_rdata1_q;
    assign a.rdata2   = a_rdata2_q;
    assign b.rdata1   = b_rdata1_q;
    assign b.rdata2   = b_rdata2_q;
    assign last_grant = last_grant_q;
    assign txn_cnt    = txn_cnt_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the arbiter.
module tb_regfile_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_arbiter_if a_if ();
    regfile_arbiter_if b_if ();

    logic [4:0]  rf_readreg1, rf_readreg2, rf_writereg;
    logic [31:0] rf_data, rf_rs1, rf_rs2;
    logic        rf_writeEn, last_grant;
    logic [7:0]  txn_cnt;

    regfile_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a_if),
        .b           (b_if),
        .rf_readreg1 (rf_readreg1),
        .rf_readreg2 (rf_readreg2),
        .rf_writereg (rf_writereg),
        .rf_data     (rf_data),
        .rf_writeEn  (rf_writeEn),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .last_grant  (last_grant),
        .txn_cnt     (txn_cnt)
    );

    // Regfile attached to the arbiter: combinational read, write at clock edge, x0 tied to 0.
    logic [31:0] rf_mem [32] = '{default: 32'h0};
    always @(posedge clk) if (rf_writeEn && rf_writereg != 5'd0) rf_mem[rf_writereg] <= rf_data;
    assign rf_rs1 = rf_mem[rf_readreg1];
    assign rf_rs2 = rf_mem[rf_readreg2];

    // Transaction-level model: register contents, outstanding response, fairness memory.
    logic [31:0] m_regs [32];
    bit          m_busy, m_owner, m_last;
    logic [7:0]  m_cnt;
    bit          m_rv [2];
    logic [31:0] m_d1 [2];
    logic [31:0] m_d2 [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_cnt   = 8'd0;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0;
            m_d1[i] = 32'h0;
            m_d2[i] = 32'h0;
        end
    endtask

    task automatic set_a(input logic v, input logic we, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] wd);
        a_if.valid = v; a_if.we = we; a_if.rs1 = rs1; a_if.rs2 = rs2; a_if.rd = rd; a_if.wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] wd);
        b_if.valid = v; b_if.we = we; b_if.rs1 = rs1; b_if.rs2 = rs2; b_if.rd = rd; b_if.wdata = wd;
    endtask

    // One clock: check the combinational grant just before the edge, then the
    // registered state just after it. Called 1 time unit after a rising edge.
    task automatic cycle(output bit ga, output bit gb);
        logic [4:0]  e_r1, e_r2, e_wr;
        logic [31:0] e_wd;
        bit          e_we, rel, w;
        #1;
        ga = 1'b0;
        gb = 1'b0;
        if (!m_busy) begin
            if (a_if.valid && b_if.valid) begin
                ga = m_last;
                gb = !m_last;
            end else begin
                ga = a_if.valid;
                gb = b_if.valid;
            end
        end
        e_r1 = 5'd0; e_r2 = 5'd0; e_wr = 5'd0; e_wd = 32'h0; e_we = 1'b0;
        if (ga) begin
            e_r1 = a_if.rs1; e_r2 = a_if.rs2; e_wr = a_if.rd; e_wd = a_if.wdata; e_we = a_if.we;
        end else if (gb) begin
            e_r1 = b_if.rs1; e_r2 = b_if.rs2; e_wr = b_if.rd; e_wd = b_if.wdata; e_we = b_if.we;
        end
        chk("a_ready", a_if.ready, ga);
        chk("b_ready", b_if.ready, gb);
        chk("rf_writeEn", rf_writeEn, e_we);
        chk("rf_readreg1", rf_readreg1, e_r1);
        chk("rf_readreg2", rf_readreg2, e_r2);
        chk("rf_writereg", rf_writereg, e_wr);
        chk("rf_data", rf_data, e_wd);
        rel = m_busy && (m_owner ? b_if.rready : a_if.rready);

        @(posedge clk);
        #1;
        if (ga || gb) begin
            w       = gb;
            m_d1[w] = m_regs[e_r1];
            m_d2[w] = m_regs[e_r2];
            if (e_we && e_wr != 5'd0) m_regs[e_wr] = e_wd;
            m_rv[w] = 1'b1;
            m_busy  = 1'b1;
            m_owner = w;
            m_last  = w;
            m_cnt   = m_cnt + 8'd1;
        end else if (rel) begin
            m_rv[m_owner] = 1'b0;
            m_busy        = 1'b0;
        end
        chk("a_rvalid", a_if.rvalid, m_rv[0]);
        chk("b_rvalid", b_if.rvalid, m_rv[1]);
        chk("a_rdata1", a_if.rdata1, m_d1[0]);
        chk("a_rdata2", a_if.rdata2, m_d2[0]);
        chk("b_rdata1", b_if.rdata1, m_d1[1]);
        chk("b_rdata2", b_if.rdata2, m_d2[1]);
        chk("last_grant", last_grant, m_last);
        chk("txn_cnt", txn_cnt, m_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ga, gb, seen_wrap;
        logic [31:0] held1, held2;

        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        model_reset();
        set_a(0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0);
        a_if.rready = 1'b0;
        b_if.rready = 1'b0;

        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_a_rvalid", a_if.rvalid, 0);
        chk("rst_b_rvalid", b_if.rvalid, 0);
        chk("rst_a_rdata1", a_if.rdata1, 0);
        chk("rst_b_rdata2", b_if.rdata2, 0);
        chk("rst_last_grant", last_grant, 1);
        chk("rst_txn_cnt", txn_cnt, 0);
        chk("rst_rf_writeEn", rf_writeEn, 0);
        chk("rst_a_ready", a_if.ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read back through requester A
        set_a(1, 1, 5, 0, 5, 32'hDEADBEEF);
        cycle(ga, gb);
        chk("t1_old_x5", a_if.rdata1, 32'h0);
        a_if.valid  = 1'b0;
        a_if.rready = 1'b1;
        cycle(ga, gb);
        set_a(1, 0, 5, 0, 0, 0);
        cycle(ga, gb);
        chk("t1_new_x5", a_if.rdata1, 32'hDEADBEEF);
        chk("t1_txn_cnt", txn_cnt, 8'd2);
        a_if.valid = 1'b0;
        cycle(ga, gb);

        // Contention from reset: grants alternate A, B, A, B every two cycles
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        set_a(1, 0, 5, 1, 0, 0);
        set_b(1, 0, 2, 5, 0, 0);
        a_if.rready = 1'b1;
        b_if.rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(ga, gb);
            if (i % 2 == 0) chk("t2_last_grant", last_grant, 32'((i / 2) % 2));
        end
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;

        // Response backpressure on B while A waits
        set_b(1, 0, 5, 2, 0, 0);
        b_if.rready = 1'b0;
        cycle(ga, gb);
        b_if.valid = 1'b0;
        held1 = b_if.rdata1;
        held2 = b_if.rdata2;
        set_a(1, 0, 1, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(ga, gb);
            chk("t3_b_rvalid_held", b_if.rvalid, 1);
            chk("t3_b_rdata1_stable", b_if.rdata1, held1);
            chk("t3_b_rdata2_stable", b_if.rdata2, held2);
        end
        b_if.rready = 1'b1;
        cycle(ga, gb);
        chk("t3_b_released", b_if.rvalid, 0);
        cycle(ga, gb);
        chk("t3_a_granted_after", a_if.rvalid, 1);
        a_if.valid = 1'b0;
        cycle(ga, gb);

        // Dual read of x1/x2
        set_a(1, 1, 0, 0, 1, 32'h11);
        cycle(ga, gb);
        a_if.valid = 1'b0;
        cycle(ga, gb);
        set_a(1, 1, 0, 0, 2, 32'h22);
        cycle(ga, gb);
        a_if.valid = 1'b0;
        cycle(ga, gb);
        set_a(1, 0, 1, 2, 0, 0);
        cycle(ga, gb);
        chk("t4_rdata1", a_if.rdata1, 32'h11);
        chk("t4_rdata2", a_if.rdata2, 32'h22);
        chk("t4_b_rvalid", b_if.rvalid, 0);
        a_if.valid = 1'b0;
        cycle(ga, gb);

        // Counter wrap under back-to-back grants
        seen_wrap = 1'b0;
        set_a(1, 0, 3, 4, 0, 0);
        for (int i = 0; i < 600 && !seen_wrap; i++) begin
            cycle(ga, gb);
            if (ga && m_cnt == 8'd0) begin
                seen_wrap = 1'b1;
                chk("t5_txn_cnt_wrapped", txn_cnt, 0);
            end
        end
        chk("t5_wrap_seen", 32'(seen_wrap), 1);
        a_if.valid = 1'b0;
        cycle(ga, gb);

        // Reset in the middle of a response; the write survives
        set_a(1, 1, 0, 0, 7, 32'h5A);
        a_if.rready = 1'b0;
        cycle(ga, gb);
        a_if.valid = 1'b0;
        chk("t6_rvalid_before", a_if.rvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rvalid_async_clear", a_if.rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("t6_last_grant", last_grant, 1);
        chk("t6_txn_cnt", txn_cnt, 0);
        set_a(1, 0, 7, 0, 0, 0);
        a_if.rready = 1'b1;
        cycle(ga, gb);
        chk("t6_x7_readback", a_if.rdata1, 32'h5A);
        a_if.valid = 1'b0;
        cycle(ga, gb);

        // Random traffic: requesters hold payload until granted
        for (int i = 0; i < 400; i++) begin
            if (!a_if.valid && $urandom_range(0, 1) == 1)
                set_a(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), $urandom);
            if (!b_if.valid && $urandom_range(0, 1) == 1)
                set_b(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), $urandom);
            a_if.rready = 1'($urandom_range(0, 1));
            b_if.rready = 1'($urandom_range(0, 1));
            cycle(ga, gb);
            if (ga) a_if.valid = 1'b0;
            if (gb) b_if.valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
